// File: rtl/rr_lock_arbiter.sv
// Output-port arbiter: picks one requester (round-robin or fixed priority) and
// locks the grant until the packet's tail is released or the requester withdraws.
module rr_lock_arbiter #(
    parameter int size    = 5,
    parameter bit RR_MODE = 1'b1,
    localparam int SEL_W  = (size > 1) ? $clog2(size) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [size-1:0]  i_requests,
    input  logic             i_enable,
    input  logic             i_release,
    output logic             o_isOutputSelected,
    output logic [SEL_W-1:0] o_selectedOutput,
    output logic [size-1:0]  o_grant,
    output logic             o_dbg_state
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SEL_W-1:0]   r_last;
    logic [SEL_W-1:0]   w_next_last;
    logic               r_valid;
    logic               w_next_valid;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_next_sel;
    logic [size-1:0]    r_grant;
    logic [size-1:0]    w_next_grant;

    logic [SEL_W-1:0]   w_winner;
    logic               w_found;
    logic [SEL_W:0]     w_cand;
    logic [size-1:0]    w_onehot;

    // Candidate index is last+k folded once at size, so non-power-of-two
    // sizes never wrap at 2^SEL_W and never yield an index >= size.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        if (RR_MODE) begin
            for (int k = 1; k <= size; k++) begin
                w_cand = {1'b0, r_last} + (SEL_W+1)'(k);
                if (w_cand >= (SEL_W+1)'(size)) begin
                    w_cand = w_cand - (SEL_W+1)'(size);
                end
                if (!w_found && i_requests[w_cand[SEL_W-1:0]]) begin
                    w_found  = 1'b1;
                    w_winner = w_cand[SEL_W-1:0];
                end
            end
        end else begin
            for (int i = 0; i < size; i++) begin
                if (!w_found && i_requests[i]) begin
                    w_found  = 1'b1;
                    w_winner = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < size; i++) begin
            w_onehot[i] = (w_winner == SEL_W'(i));
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_last  = r_last;
        w_next_valid = r_valid;
        w_next_sel   = r_sel;
        w_next_grant = r_grant;
        case (r_state)
            S_IDLE: begin
                if (i_enable && w_found) begin
                    w_next_state = S_GRANTED;
                    w_next_valid = 1'b1;
                    w_next_sel   = w_winner;
                    w_next_grant = w_onehot;
                end else begin
                    w_next_valid = 1'b0;
                    w_next_sel   = '0;
                    w_next_grant = '0;
                end
            end
            S_GRANTED: begin
                // Leaving always passes through IDLE, so no same-edge re-grant.
                if (i_release || !i_requests[r_sel]) begin
                    w_next_state = S_IDLE;
                    w_next_last  = r_sel;
                    w_next_valid = 1'b0;
                    w_next_sel   = '0;
                    w_next_grant = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_valid = 1'b0;
                w_next_sel   = '0;
                w_next_grant = '0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_last  <= SEL_W'(size - 1);
            r_valid <= 1'b0;
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_next_state;
            r_last  <= w_next_last;
            r_valid <= w_next_valid;
            r_sel   <= w_next_sel;
            r_grant <= w_next_grant;
        end
    end

    assign o_isOutputSelected = r_valid;
    assign o_selectedOutput   = r_sel;
    assign o_grant            = r_grant;
    assign o_dbg_state        = (r_state == S_GRANTED);

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Registered, parametrised arbiter for one Phoenix router output port.
- Selects one of `size` input requests and holds that grant until the packet completes.
- Selectable policy: round-robin (default) or fixed-priority with port 0 highest.
- Feeds the crossbar select and the switch-control FSM; replaces purely combinational selection where fairness and grant locking are needed.

Parameters:
- size, `NPORT (5), number of requesting ports.
- RR_MODE, 1, 1 = round-robin search starting after last winner; 0 = fixed priority, lowest index wins.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- requests  input  size  per-port request, level, held by requester until served.
- enable  input  1  permits a new arbitration; does not affect a held grant.
- release  input  1  one-cycle pulse from switch control: granted packet finished (tail flit sent).
- isOutputSelected  output  1  registered; high while a grant is held.
- selectedOutput  output  $clog2(size)  registered index of granted port.
- grant  output  size  registered one-hot grant; all-zero when isOutputSelected=0.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, isOutputSelected=0, selectedOutput=0, grant=0.
  - Priority pointer last=size-1, so port 0 has first priority after reset.
- States: IDLE, GRANTED.
- IDLE:
  - If enable=1 and |requests, compute winner combinationally.
  - Register winner on the next rising edge: isOutputSelected=1, selectedOutput=winner, grant[winner]=1, state->GRANTED.
  - Latency: request/enable sampled at edge N, grant visible after edge N.
  - If enable=0 or requests=0: stay IDLE, outputs zero.
- Winner:
  - RR_MODE=1: first asserted index in the order last+1, last+2, ..., wrapping modulo size, ending at last.
  - RR_MODE=0: lowest asserted index; pointer ignored.
- GRANTED:
  - Outputs held constant regardless of enable or other requests.
  - On release=1, or requests[selectedOutput]=0 (requester withdrew): next edge clears outputs, sets last=selectedOutput, state->IDLE.
  - Pointer update happens in both modes; it only influences RR_MODE=1.
  - One mandatory IDLE cycle follows every grant. No back-to-back re-grant in the release cycle.
- release while IDLE: ignored, no state change.
- Simultaneous release and new requests: release wins. New arbitration occurs in the following IDLE cycle using the updated pointer.
- Wrap-around: last=size-1 searches from 0. A single requester equal to last is still granted (full circle).
- Non-power-of-two size:
  - Indices size..2^clog2(size)-1 are never produced.
  - Pointer arithmetic wraps at size, not at 2^width.
- Reset mid-grant: outputs drop asynchronously. The pointer returns to size-1, so the pre-reset winner gets no history.
- selectedOutput and grant always agree: grant == (1<<selectedOutput) when isOutputSelected=1.

Test Plan:
1. Reset, then requests=5'b10110, enable=1 (RR) -> one edge later isOutputSelected=1, selectedOutput=1, grant=5'b00010; hold unchanged for 10 cycles with requests constant.
2. From 1, pulse release -> next edge outputs 0. Next edge: selectedOutput=2, grant=5'b00100. Then release -> selectedOutput=4. Then release -> selectedOutput=1 (wrap past 0, which is not requesting).
3. RR_MODE=0, requests=5'b11110, repeated release pulses -> selectedOutput=1 every time; never 2, 3 or 4.
4. Grant held on port 3, enable=0 and requests[3] stays 1 -> grant held. Then drop requests[3] -> next edge isOutputSelected=0, last=3. Re-enable with requests=5'b01001 -> selectedOutput=0.
5. Single requester port 4 with last=4 (after serving 4), requests=5'b10000 -> after one IDLE cycle, selectedOutput=4 again.
6. Assert reset asynchronously mid-cycle while granted on port 2 -> outputs zero before next clock edge. After deassert with requests=5'b11111 -> selectedOutput=0.
